// File: rtl/wb_cmd_sequencer.sv
// wb_cmd_sequencer: queues host command words and services ADC interrupt
// lines with automatic read/flush sequences, issuing each beat to the
// Wishbone SPI master command port with a stall-aware strobe.
module wb_cmd_sequencer #(
  parameter int          NCH           = 4,
  parameter int          CHW           = 2,
  parameter int          HOST_DEPTH    = 4,
  parameter int          STB_CYCLES    = 2,
  parameter int          GAP_CYCLES    = 1,
  parameter logic [33:0] READ_CMD      = 34'h200000001,
  parameter logic [33:0] FLUSH_CMD     = 34'h000000000,
  parameter bit          HOST_PRIORITY = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     ep_dataout,
  input  logic            trigger,
  input  logic [NCH-1:0]  int_i,
  input  logic            auto_en,
  input  logic            i_stall,
  input  logic            clr_flags,
  output logic            o_stb,
  output logic [33:0]     cmd_word,
  output logic [CHW-1:0]  o_chan,
  output logic            o_busy,
  output logic            o_ovf,
  output logic [NCH-1:0]  o_int_miss
);

  localparam int AW  = $clog2(HOST_DEPTH);
  localparam int SCW = $clog2(STB_CYCLES + 1);
  localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, BEAT, GAP} state_t;
  typedef enum logic [1:0] {SEQ_HOST, SEQ_AUTO1, SEQ_AUTO2} seq_t;

  // ---------------------------------------------------------------------------
  // Host FIFO
  // ---------------------------------------------------------------------------
  logic [33:0]   fifo_mem [HOST_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full, fifo_empty;
  logic [33:0]   fifo_head;
  logic          host_pop, push_ok, ovf_set;

  assign fifo_full  = (fifo_cnt == (AW+1)'(HOST_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_head  = fifo_mem[rd_ptr];
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push_ok    = trigger & (~fifo_full | host_pop);
  assign ovf_set    = trigger & fifo_full & ~host_pop;

  // FIFO pointers and occupancy.
  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok)  wr_ptr <= wr_ptr + 1'b1;
      if (host_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, host_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage write; host bits 31:30 become the top two command bits.
  // NOTE: the storage array has no reset; emptiness is tracked by the
  // pointers, so clearing the data would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= {ep_dataout[31:30], 2'b00, ep_dataout[29:0]};
  end

  // ---------------------------------------------------------------------------
  // Interrupt pending latch and round-robin pick
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] int_prev, pending, int_rise, grant_mask, miss_set;
  logic [CHW-1:0] rr, pick_idx;
  logic           pick_found;
  logic           auto_grant;

  assign int_rise   = int_i & ~int_prev;
  assign grant_mask = auto_grant ? (NCH'(1) << pick_idx) : '0;
  // A rise on the edge the channel is granted re-arms it without a miss.
  assign miss_set   = int_rise & pending & ~grant_mask;

  // First pending channel at or after the round-robin pointer.
  always_comb begin
    int k;
    k          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      k = int'(rr) + i;
      if (k >= NCH) k = k - NCH;
      if (!pick_found && pending[k]) begin
        pick_found = 1'b1;
        pick_idx   = CHW'(k);
      end
    end
  end

  // Edge detection, pending bits and sticky flags (a same-edge set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_prev   <= '0;
      pending    <= '0;
      o_int_miss <= '0;
      o_ovf      <= 1'b0;
    end else begin
      int_prev   <= int_i;
      pending    <= int_rise | (pending & ~grant_mask);
      o_int_miss <= miss_set | (clr_flags ? '0 : o_int_miss);
      o_ovf      <= ovf_set | (~clr_flags & o_ovf);
    end
  end

  // ---------------------------------------------------------------------------
  // Beat sequencer FSM
  // ---------------------------------------------------------------------------
  state_t         state, state_nxt;
  seq_t           seq, seq_nxt;
  logic [SCW-1:0] stb_cnt, stb_cnt_nxt;
  logic [GCW-1:0] gap_cnt, gap_cnt_nxt;
  logic           stb_nxt;
  logic [33:0]    cmd_nxt;
  logic [CHW-1:0] chan_nxt, rr_nxt;
  logic           host_cand, auto_cand;

  assign host_cand = ~fifo_empty;
  assign auto_cand = auto_en & pick_found;
  assign o_busy    = (state != IDLE);

  // Next-state, arbitration and registered-output values.
  // NOTE: every signal gets its default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    seq_nxt     = seq;
    stb_cnt_nxt = stb_cnt;
    gap_cnt_nxt = gap_cnt;
    stb_nxt     = o_stb;
    cmd_nxt     = cmd_word;
    chan_nxt    = o_chan;
    rr_nxt      = rr;
    host_pop    = 1'b0;
    auto_grant  = 1'b0;
    case (state)
      IDLE: begin
        if (host_cand && (HOST_PRIORITY || !auto_cand)) begin
          host_pop    = 1'b1;
          cmd_nxt     = fifo_head;
          chan_nxt    = '0;
          stb_nxt     = 1'b1;
          stb_cnt_nxt = '0;
          seq_nxt     = SEQ_HOST;
          state_nxt   = BEAT;
        end else if (auto_cand) begin
          auto_grant  = 1'b1;
          cmd_nxt     = READ_CMD;
          chan_nxt    = pick_idx;
          stb_nxt     = 1'b1;
          stb_cnt_nxt = '0;
          seq_nxt     = SEQ_AUTO1;
          state_nxt   = BEAT;
          rr_nxt      = (pick_idx == CHW'(NCH - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      BEAT: begin
        // Only accepted strobe cycles count, so a stall can only stretch a beat.
        if (o_stb && !i_stall) begin
          if (stb_cnt == SCW'(STB_CYCLES - 1)) begin
            stb_cnt_nxt = '0;
            if (GAP_CYCLES > 0) begin
              stb_nxt     = 1'b0;
              gap_cnt_nxt = '0;
              state_nxt   = GAP;
            end else if (seq == SEQ_AUTO1) begin
              cmd_nxt = FLUSH_CMD;
              seq_nxt = SEQ_AUTO2;
            end else begin
              stb_nxt   = 1'b0;
              state_nxt = IDLE;
            end
          end else begin
            stb_cnt_nxt = stb_cnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GCW'(GAP_CYCLES - 1)) begin
          gap_cnt_nxt = '0;
          if (seq == SEQ_AUTO1) begin
            cmd_nxt   = FLUSH_CMD;
            stb_nxt   = 1'b1;
            seq_nxt   = SEQ_AUTO2;
            state_nxt = BEAT;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and registered command-port outputs; reset drops any beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      seq      <= SEQ_HOST;
      stb_cnt  <= '0;
      gap_cnt  <= '0;
      o_stb    <= 1'b0;
      cmd_word <= '0;
      o_chan   <= '0;
      rr       <= '0;
    end else begin
      state    <= state_nxt;
      seq      <= seq_nxt;
      stb_cnt  <= stb_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      o_stb    <= stb_nxt;
      cmd_word <= cmd_nxt;
      o_chan   <= chan_nxt;
      rr       <= rr_nxt;
    end
  end

endmodule

// File: tb/tb_wb_cmd_sequencer.sv
// Self-checking bench for wb_cmd_sequencer: directed scenarios plus random
// stimulus compared every cycle against a beat-list reference model.
module tb_wb_cmd_sequencer;

  localparam int          NCH           = 4;
  localparam int          CHW           = 2;
  localparam int          HOST_DEPTH    = 4;
  localparam int          STB_CYCLES    = 2;
  localparam int          GAP_CYCLES    = 1;
  localparam logic [33:0] READ_CMD      = 34'h200000001;
  localparam logic [33:0] FLUSH_CMD     = 34'h000000000;
  localparam bit          HOST_PRIORITY = 1'b0;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     ep_dataout;
  logic            trigger;
  logic [NCH-1:0]  int_i;
  logic            auto_en;
  logic            i_stall;
  logic            clr_flags;
  logic            o_stb;
  logic [33:0]     cmd_word;
  logic [CHW-1:0]  o_chan;
  logic            o_busy;
  logic            o_ovf;
  logic [NCH-1:0]  o_int_miss;

  wb_cmd_sequencer #(
    .NCH(NCH), .CHW(CHW), .HOST_DEPTH(HOST_DEPTH), .STB_CYCLES(STB_CYCLES),
    .GAP_CYCLES(GAP_CYCLES), .READ_CMD(READ_CMD), .FLUSH_CMD(FLUSH_CMD),
    .HOST_PRIORITY(HOST_PRIORITY)
  ) dut (
    .clk(clk), .rst(rst), .ep_dataout(ep_dataout), .trigger(trigger),
    .int_i(int_i), .auto_en(auto_en), .i_stall(i_stall), .clr_flags(clr_flags),
    .o_stb(o_stb), .cmd_word(cmd_word), .o_chan(o_chan), .o_busy(o_busy),
    .o_ovf(o_ovf), .o_int_miss(o_int_miss)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] fmt(input logic [31:0] d);
    return {d[31:30], 2'b00, d[29:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: a sequence is a list of beats; the head beat is issued
  // until STB_CYCLES unstalled cycles are accepted, then GAP_CYCLES idle.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [33:0] cmd;
    int          chan;
  } beat_t;

  logic [33:0]    m_q[$];
  beat_t          m_beats[$];
  logic [NCH-1:0] m_pend, m_prev, m_miss;
  bit             m_ovf, m_active, m_in_gap;
  int             m_acc, m_gap, m_rr, m_chan;
  logic [33:0]    m_cmd;

  task automatic model_reset();
    m_q.delete();
    m_beats.delete();
    m_pend = '0; m_prev = '0; m_miss = '0;
    m_ovf = 0; m_active = 0; m_in_gap = 0;
    m_acc = 0; m_gap = 0; m_rr = 0; m_chan = 0; m_cmd = '0;
  endtask

  task automatic start_head();
    if (m_beats.size() > 0) begin
      m_cmd    = m_beats[0].cmd;
      m_chan   = m_beats[0].chan;
      m_acc    = 0;
      m_in_gap = 0;
      m_active = 1;
    end else begin
      m_active = 0;
      m_in_gap = 0;
    end
  endtask

  task automatic model_step();
    bit          full, host_g, auto_req;
    int          g;
    beat_t       b;
    logic [NCH-1:0] rise;
    full     = (m_q.size() == HOST_DEPTH);
    auto_req = auto_en && (m_pend != '0);
    host_g   = 0;
    g        = -1;
    if (!m_active) begin
      if (m_q.size() > 0 && (HOST_PRIORITY || !auto_req)) host_g = 1;
      else if (auto_req) begin
        for (int i = 0; i < NCH; i++) begin
          if (g < 0 && m_pend[(m_rr + i) % NCH]) g = (m_rr + i) % NCH;
        end
      end
    end else if (!m_in_gap) begin
      if (!i_stall) begin
        m_acc++;
        if (m_acc == STB_CYCLES) begin
          void'(m_beats.pop_front());
          if (GAP_CYCLES > 0) begin
            m_in_gap = 1;
            m_gap    = GAP_CYCLES;
          end else start_head();
        end
      end
    end else begin
      m_gap--;
      if (m_gap == 0) start_head();
    end
    if (host_g) begin
      b.cmd = m_q.pop_front(); b.chan = 0;
      m_beats.push_back(b);
      start_head();
    end
    if (g >= 0) begin
      b.cmd = READ_CMD;  b.chan = g; m_beats.push_back(b);
      b.cmd = FLUSH_CMD; b.chan = g; m_beats.push_back(b);
      start_head();
      m_rr = (g + 1) % NCH;
    end
    if (trigger && (!full || host_g)) m_q.push_back(fmt(ep_dataout));
    if (trigger && full && !host_g) m_ovf = 1;
    else if (clr_flags) m_ovf = 0;
    rise = int_i & ~m_prev;
    for (int k = 0; k < NCH; k++) begin
      if (rise[k]) begin
        if (m_pend[k] && g != k) m_miss[k] = 1'b1;
        else if (clr_flags) m_miss[k] = 1'b0;
        m_pend[k] = 1'b1;
      end else begin
        if (clr_flags) m_miss[k] = 1'b0;
        if (g == k) m_pend[k] = 1'b0;
      end
    end
    m_prev = int_i;
  endtask

  task automatic compare_model();
    bit exp_stb;
    exp_stb = m_active && !m_in_gap;
    check("stb", o_stb, exp_stb);
    check("busy", o_busy, m_active);
    check("ovf", o_ovf, m_ovf);
    check("int_miss", o_int_miss, m_miss);
    if (exp_stb) begin
      check("cmd_word", cmd_word, m_cmd);
      check("chan", o_chan, m_chan);
    end
  endtask

  // Beat log: one entry per rising edge of o_stb.
  logic [33:0] log_cmd[$];
  int          log_chan[$];
  bit          prev_stb;

  task automatic clear_log();
    log_cmd.delete();
    log_chan.delete();
  endtask

  // Inputs are driven at the falling edge; outputs checked at the next one.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_model();
    if (o_stb && !prev_stb) begin
      log_cmd.push_back(cmd_word);
      log_chan.push_back(int'(o_chan));
    end
    prev_stb = o_stb;
  endtask

  task automatic do_reset();
    rst = 1'b1; trigger = 1'b0; int_i = '0; auto_en = 1'b1;
    i_stall = 1'b0; clr_flags = 1'b0; ep_dataout = '0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    compare_model();
    check("rst_cmd", cmd_word, 34'h0);
    check("rst_chan", o_chan, 0);
    rst = 1'b0;
    prev_stb = 1'b0;
    clear_log();
  endtask

  task automatic async_reset();
    trigger = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_stb", o_stb, 0);
    check("arst_cmd", cmd_word, 34'h0);
    check("arst_chan", o_chan, 0);
    check("arst_busy", o_busy, 0);
    check("arst_ovf", o_ovf, 0);
    check("arst_miss", o_int_miss, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    prev_stb = 1'b0;
    clear_log();
  endtask

  initial begin
    int          stb_n, busy_n, rd_n, fl_n;
    logic [31:0] w[6];
    logic [33:0] hw;

    // 1: single host command, latency and widths.
    do_reset();
    ep_dataout = 32'hC0000005; trigger = 1'b1;
    step();
    trigger = 1'b0;
    check("t1_stb_e0", o_stb, 0);
    stb_n = 0; busy_n = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) check("t1_stb_e1", o_stb, 1);
      if (o_stb) begin
        stb_n++;
        check("t1_cmd", cmd_word, 34'h300000005);
      end
      if (o_busy) busy_n++;
    end
    check("t1_stb_width", stb_n, 2);
    check("t1_busy_width", busy_n, 3);

    // 2: auto read/flush sequence on channel 2.
    do_reset();
    int_i = 4'b0100;
    step();
    int_i = '0;
    rd_n = 0; fl_n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_stb && cmd_word == READ_CMD)  rd_n++;
      if (o_stb && cmd_word == FLUSH_CMD) fl_n++;
    end
    check("t2_beats", log_cmd.size(), 2);
    check("t2_read", log_cmd[0], READ_CMD);
    check("t2_flush", log_cmd[1], FLUSH_CMD);
    check("t2_chan0", log_chan[0], 2);
    check("t2_chan1", log_chan[1], 2);
    check("t2_read_width", rd_n, 2);
    check("t2_flush_width", fl_n, 2);

    // 3: stall stretches a beat, word held steady.
    do_reset();
    ep_dataout = $urandom; hw = fmt(ep_dataout); trigger = 1'b1;
    step();
    trigger = 1'b0;
    stb_n = 0;
    for (int i = 0; i < 12; i++) begin
      i_stall = (i >= 1 && i <= 3);
      step();
      if (o_stb) begin
        stb_n++;
        check("t3_cmd_stable", cmd_word, hw);
      end
    end
    i_stall = 1'b0;
    check("t3_stb_width", stb_n, 5);

    // 4: FIFO overflow while busy.
    do_reset();
    for (int i = 0; i < 6; i++) w[i] = $urandom;
    ep_dataout = w[0]; trigger = 1'b1;
    step();
    for (int i = 1; i < 6; i++) begin
      ep_dataout = w[i]; i_stall = 1'b1;
      step();
    end
    trigger = 1'b0; i_stall = 1'b0;
    check("t4_ovf_set", o_ovf, 1);
    for (int i = 0; i < 30; i++) step();
    check("t4_issued", log_cmd.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("t4_word%0d", i), log_cmd[i], fmt(w[i]));
    check("t4_ovf_sticky", o_ovf, 1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("t4_ovf_clr", o_ovf, 0);

    // 5: simultaneous rises, one missed re-rise, round-robin order.
    do_reset();
    auto_en = 1'b0;
    int_i = 4'b1001; step();
    int_i = 4'b1000; step();
    int_i = 4'b1001; step();
    check("t5_miss", o_int_miss, 4'b0001);
    auto_en = 1'b1;
    int_i = '0;
    for (int i = 0; i < 16; i++) step();
    check("t5_beats", log_cmd.size(), 4);
    check("t5_chan0", log_chan[0], 0);
    check("t5_chan1", log_chan[1], 0);
    check("t5_chan2", log_chan[2], 3);
    check("t5_chan3", log_chan[3], 3);
    check("t5_miss_sticky", o_int_miss, 4'b0001);

    // 6: host and auto on the same edge, then reset mid-beat.
    do_reset();
    ep_dataout = $urandom; hw = fmt(ep_dataout);
    trigger = 1'b1; int_i = 4'b0010;
    step();
    trigger = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check("t6_beats", log_cmd.size(), 3);
    check("t6_first", log_cmd[0], READ_CMD);
    check("t6_second", log_cmd[1], FLUSH_CMD);
    check("t6_host", log_cmd[2], hw);
    check("t6_chan_auto", log_chan[0], 1);
    check("t6_chan_host", log_chan[2], 0);
    ep_dataout = $urandom; trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    check("t6_midbeat_stb", o_stb, 1);
    async_reset();
    for (int i = 0; i < 10; i++) step();
    check("t6_post_beats", log_cmd.size(), 2);
    check("t6_post_read", log_cmd[0], READ_CMD);
    check("t6_post_chan", log_chan[0], 1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      trigger    = ($urandom_range(0, 3) == 0);
      ep_dataout = $urandom;
      for (int k = 0; k < NCH; k++)
        if ($urandom_range(0, 7) == 0) int_i[k] = ~int_i[k];
      auto_en    = ($urandom_range(0, 7) != 0);
      i_stall    = ($urandom_range(0, 3) == 0);
      clr_flags  = ($urandom_range(0, 31) == 0);
      if (i == 1500) async_reset();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
